// File: rtl/axi4_slave_pkg.sv
// Shared constants and FSM state types for the AXI4 slave memory model.
package axi4_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } write_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } read_state_e;

endpackage

// File: rtl/axi4_burst_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// The reserved burst code falls through to INCR.
module axi4_burst_addr
  import axi4_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr_c
);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    incr        = ADDR_W'(1) << size;
    wrap_mask   = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    next_addr_c = addr + incr;
    case (burst)
      BURST_FIXED: next_addr_c = addr;
      BURST_INCR:  next_addr_c = addr + incr;
      BURST_WRAP:  next_addr_c = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
      default:     next_addr_c = addr + incr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: independent write/read burst engines over byte-strobed storage.
// Define AXI4_SLV_ERR_EN to flag out-of-range beats with SLVERR instead of wrapping modulo DEPTH.
module axi4_slave_mem
  import axi4_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  write_state_e      wstate;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic [7:0]        w_beat;
  logic              w_err;

  read_state_e       rstate;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [7:0]        r_beat;

  logic [ADDR_W-1:0] w_next_c, r_next_c, rd_addr_c, w_word_c, rd_word_addr_c;
  logic [IDX_W-1:0]  w_idx_c, rd_idx_c;
  logic              w_oor_c, rd_oor_c, w_fire_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [1:0]        rd_resp_c;

  axi4_burst_addr #(.ADDR_W(ADDR_W)) u_waddr (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr_c(w_next_c)
  );

  axi4_burst_addr #(.ADDR_W(ADDR_W)) u_raddr (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr_c(r_next_c)
  );

  // The read port looks at araddr while idle, otherwise at the following beat's address.
  assign rd_addr_c      = (rstate == R_IDLE) ? araddr : r_next_c;
  assign w_word_c       = w_addr >> LSB;
  assign rd_word_addr_c = rd_addr_c >> LSB;

`ifdef AXI4_SLV_ERR_EN
  assign w_oor_c  = (w_word_c >= ADDR_W'(DEPTH));
  assign rd_oor_c = (rd_word_addr_c >= ADDR_W'(DEPTH));
  assign w_idx_c  = IDX_W'(w_word_c);
  assign rd_idx_c = IDX_W'(rd_word_addr_c);
`else
  assign w_oor_c  = 1'b0;
  assign rd_oor_c = 1'b0;
  assign w_idx_c  = IDX_W'(w_word_c % ADDR_W'(DEPTH));
  assign rd_idx_c = IDX_W'(rd_word_addr_c % ADDR_W'(DEPTH));
`endif

  assign rd_word_c = rd_oor_c ? '0 : mem[rd_idx_c];
  assign rd_resp_c = rd_oor_c ? RESP_SLVERR : RESP_OKAY;
  assign w_fire_c  = (wstate == W_DATA) && wvalid && wready && !w_oor_c && !reset;

  // Storage is never reset; nonblocking update gives read-first on collisions.
  always_ff @(posedge clock) begin
    if (w_fire_c) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[w_idx_c][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate  <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      case (wstate)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          // Burst length, not wlast, ends the burst; a wlast mismatch only flags SLVERR.
          if (wvalid && wready) begin
            if (w_beat == w_len) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= w_id;
              bresp  <= (w_err || !wlast || w_oor_c) ? RESP_SLVERR : RESP_OKAY;
              wstate <= W_RESP;
            end else begin
              w_err  <= w_err | wlast | w_oor_c;
              w_beat <= w_beat + 8'd1;
              w_addr <= w_next_c;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_beat  <= '0;
            rid     <= arid;
            rdata   <= rd_word_c;
            rresp   <= rd_resp_c;
            rlast   <= (arlen == 8'd0);
            rvalid  <= 1'b1;
            arready <= 1'b0;
            rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              r_addr <= r_next_c;
              r_beat <= r_beat + 8'd1;
              rdata  <= rd_word_c;
              rresp  <= rd_resp_c;
              rlast  <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: bursts, wrap, stalls, strobes, wlast errors, reset mid-burst.
// Out-of-range expectations follow AXI4_SLV_ERR_EN.
module tb_axi4_slave_mem;

  localparam int unsigned DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] wbuf  [16];
  logic [31:0] exp_d [16];

  axi4_slave_mem #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return awready;
      1:       return wready;
      2:       return bvalid;
      3:       return arready;
      4:       return rvalid;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait on a handshake signal; expiry shows up as a failed check.
  task automatic wait_for(input int which, input string tag);
    int n = 0;
    while (!sig(which) && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, 64'(sig(which)), 64'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] strb, input int last_beat, input int nsend,
                          input logic [3:0] id, output logic [1:0] resp, output logic [3:0] got_id);
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    wait_for(0, "awready_wait");
    @(posedge clock); #1;
    awvalid = 1'b0;
    for (int b = 0; b < nsend; b++) begin
      wdata = wbuf[b]; wstrb = strb; wlast = (b == last_beat); wvalid = 1'b1;
      wait_for(1, "wready_wait");
      @(posedge clock); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    resp = 2'b11; got_id = '0;
    if (nsend == int'(len) + 1) begin
      bready = 1'b1;
      wait_for(2, "bvalid_wait");
      resp = bresp; got_id = bid;
      @(posedge clock); #1;
      bready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input int stall_beat, input logic [1:0] eresp);
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    wait_for(3, "arready_wait");
    @(posedge clock); #1;
    arvalid = 1'b0; rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      wait_for(4, "rvalid_wait");
      check("rdata", 64'(rdata), 64'(exp_d[b]));
      check("rlast", 64'(rlast), 64'(b == int'(len)));
      check("rresp", 64'(rresp), 64'(eresp));
      check("rid", 64'(rid), 64'(id));
      if (b == stall_beat) begin
        rready = 1'b0;
        repeat (3) begin
          @(posedge clock); #1;
          check("stall_rdata", 64'(rdata), 64'(exp_d[b]));
          check("stall_rlast", 64'(rlast), 64'(b == int'(len)));
          check("stall_rvalid", 64'(rvalid), 64'd1);
        end
        rready = 1'b1;
      end
      @(posedge clock); #1;
    end
    rready = 1'b0;
    check("rvalid_drop", 64'(rvalid), 64'd0);
  endtask

  logic [1:0] resp;
  logic [3:0] gid;

  initial begin
    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_bid_bresp", 64'({bid, bresp}), 64'd0);
    check("rst_rid_rresp", 64'({rid, rresp}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_arready", 64'(arready), 64'd1);

    // INCR write/read at 0x10
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_write(32'h10, 8'd3, 2'b01, 4'hF, 3, 4, 4'd5, resp, gid);
    check("incr_bresp", 64'(resp), 64'd0);
    check("incr_bid", 64'(gid), 64'd5);
    for (int i = 0; i < 4; i++) exp_d[i] = 32'hA0 + 32'(i);
    do_read(32'h10, 8'd3, 2'b01, 4'd9, -1, 2'b00);

    // WRAP write from 0x38 lands at 0x38,0x3C,0x30,0x34
    wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2; wbuf[3] = 32'hB3;
    do_write(32'h38, 8'd3, 2'b10, 4'hF, 3, 4, 4'd2, resp, gid);
    check("wrap_bresp", 64'(resp), 64'd0);
    exp_d[0] = 32'hB2; exp_d[1] = 32'hB3; exp_d[2] = 32'hB0; exp_d[3] = 32'hB1;
    do_read(32'h30, 8'd3, 2'b01, 4'd3, -1, 2'b00);
    // WRAP read with a 3-cycle rready stall on beat 1
    exp_d[0] = 32'hB0; exp_d[1] = 32'hB1; exp_d[2] = 32'hB2; exp_d[3] = 32'hB3;
    do_read(32'h38, 8'd3, 2'b10, 4'd4, 1, 2'b00);

    // Partial strobes
    wbuf[0] = 32'hFFFF_FFFF;
    do_write(32'h100, 8'd0, 2'b01, 4'hF, 0, 1, 4'd1, resp, gid);
    wbuf[0] = 32'h1234_5678;
    do_write(32'h100, 8'd0, 2'b01, 4'b0101, 0, 1, 4'd1, resp, gid);
    check("strb_bresp", 64'(resp), 64'd0);
    exp_d[0] = 32'hFF34_FF78;
    do_read(32'h100, 8'd0, 2'b01, 4'd1, -1, 2'b00);

    // FIXED burst: every beat hits the same word
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1; wbuf[2] = 32'hC2;
    do_write(32'h300, 8'd2, 2'b00, 4'hF, 2, 3, 4'd6, resp, gid);
    check("fixed_bresp", 64'(resp), 64'd0);
    exp_d[0] = 32'hC2; exp_d[1] = 32'hC2; exp_d[2] = 32'hC2;
    do_read(32'h300, 8'd2, 2'b00, 4'd6, -1, 2'b00);

    // wlast errors: missing on final beat, early on first beat
    wbuf[0] = 32'h11; wbuf[1] = 32'h22;
    do_write(32'h200, 8'd1, 2'b01, 4'hF, 99, 2, 4'd7, resp, gid);
    check("nolast_bresp", 64'(resp), 64'd2);
    check("nolast_bid", 64'(gid), 64'd7);
    exp_d[0] = 32'h11; exp_d[1] = 32'h22;
    do_read(32'h200, 8'd1, 2'b01, 4'd7, -1, 2'b00);
    do_write(32'h200, 8'd1, 2'b01, 4'hF, 0, 2, 4'd8, resp, gid);
    check("early_last_bresp", 64'(resp), 64'd2);

    // Out-of-range / modulo addressing
    wbuf[0] = 32'hD00D_0000;
    do_write(32'h0, 8'd0, 2'b01, 4'hF, 0, 1, 4'd0, resp, gid);
`ifdef AXI4_SLV_ERR_EN
    wbuf[0] = 32'hBAD0_BAD0;
    do_write(32'(DEPTH * 4), 8'd0, 2'b01, 4'hF, 0, 1, 4'd0, resp, gid);
    check("oor_bresp", 64'(resp), 64'd2);
    exp_d[0] = 32'h0;
    do_read(32'(DEPTH * 4), 8'd0, 2'b01, 4'd2, -1, 2'b10);
    exp_d[0] = 32'hD00D_0000;
    do_read(32'h0, 8'd0, 2'b01, 4'd2, -1, 2'b00);
`else
    exp_d[0] = 32'hD00D_0000;
    do_read(32'(DEPTH * 4), 8'd0, 2'b01, 4'd2, -1, 2'b00);
`endif

    // Reset after 2 of 4 write beats
    wbuf[0] = 32'hE0; wbuf[1] = 32'hE1; wbuf[2] = 32'hE2; wbuf[3] = 32'hE3;
    do_write(32'h400, 8'd3, 2'b01, 4'hF, 3, 2, 4'd3, resp, gid);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_wready", 64'(wready), 64'd0);
    @(posedge clock); #1;
    check("midrst_awready", 64'(awready), 64'd1);
    check("midrst_bvalid", 64'(bvalid), 64'd0);
    exp_d[0] = 32'hE0; exp_d[1] = 32'hE1;
    do_read(32'h400, 8'd1, 2'b01, 4'd5, -1, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
